// File: rtl/ws2812_pkg.sv
// Shared types and constants for the WS2812 LED datapath.
// Used by pattern_controller and ws2812_frame_scheduler.
package ws2812_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT_TX,
        LATCH
    } state_t;

    // Colors are packed G[23:16], R[15:8], B[7:0]
    localparam logic [23:0] GRB_BLACK = 24'h000000;
    localparam logic [23:0] GRB_RED   = 24'h00FF00;
    localparam logic [23:0] GRB_GREEN = 24'hFF0000;
    localparam logic [23:0] GRB_BLUE  = 24'h0000FF;
    localparam logic [23:0] GRB_WHITE = 24'hFFFFFF;

    localparam int LATCH_US_DEFAULT = 60;

    function automatic int latch_cycles(input int clk_hz, input int latch_us);
        return clk_hz / 1_000_000 * latch_us;
    endfunction

endpackage

// File: rtl/ws2812_frame_scheduler_latch_timer.sv
// Latch-gap down-counter: load, decrement while running, flag the
// final cycle so the owner can leave the gap exactly on time.
module ws2812_latch_timer
    import ws2812_pkg::*;
#(
    parameter int LATCH_CYC = 6000
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic run,
    output logic done
);

    localparam int W = (LATCH_CYC > 1) ? $clog2(LATCH_CYC) : 1;
    localparam logic [W-1:0] LOAD_VAL = W'(LATCH_CYC - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= LOAD_VAL;
        end else if (run && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    // High in the cycle whose edge brings the count to zero
    assign done = run && (cnt == W'(1));

endmodule

// File: rtl/ws2812_frame_scheduler.sv
// Frame scheduler: shadow-buffers frames, streams GRB words over
// valid/ready, then holds the WS2812 latch gap before the next frame.
module ws2812_frame_scheduler
    import ws2812_pkg::*;
#(
    parameter int NUM_LED  = 8,
    parameter int CLK_HZ   = 100_000_000,
    parameter int LATCH_US = LATCH_US_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  frame_start,
    input  logic [NUM_LED*24-1:0] frame_data,
    output logic [23:0]           pix_data,
    output logic                  pix_valid,
    input  logic                  pix_ready,
    output logic                  pix_last,
    input  logic                  tx_idle,
    output logic                  busy,
    output logic                  frame_done,
    output logic [7:0]            overrun_cnt
);

    localparam int LATCH_CYC = latch_cycles(CLK_HZ, LATCH_US);
    localparam int IW = (NUM_LED > 1) ? $clog2(NUM_LED) : 1;
    localparam logic [IW-1:0] LAST = IW'(NUM_LED - 1);

    state_t                state;
    logic [NUM_LED*24-1:0] shadow;
    logic [NUM_LED*24-1:0] active;
    logic                  pending;
    logic [IW-1:0]         idx;
    logic [IW-1:0]         nxt;
    logic                  consume;
    logic                  lat_load;
    logic                  lat_run;
    logic                  lat_done;

    assign nxt      = idx + 1'b1;
    assign consume  = (state == IDLE) && pending;
    assign lat_load = (state == WAIT_TX) && tx_idle;
    assign lat_run  = (state == LATCH);

    ws2812_latch_timer #(
        .LATCH_CYC(LATCH_CYC)
    ) u_timer (
        .clk  (clk),
        .reset(reset),
        .load (lat_load),
        .run  (lat_run),
        .done (lat_done)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            shadow      <= '0;
            active      <= '0;
            pending     <= 1'b0;
            idx         <= '0;
            pix_data    <= '0;
            pix_valid   <= 1'b0;
            pix_last    <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            overrun_cnt <= '0;
        end else begin
            frame_done <= 1'b0;

            // A capture in the consume cycle refills the slot, not an overrun
            if (frame_start) begin
                shadow  <= frame_data;
                pending <= 1'b1;
                if (pending && !consume && overrun_cnt != 8'hFF)
                    overrun_cnt <= overrun_cnt + 1'b1;
            end else if (consume) begin
                pending <= 1'b0;
            end

            unique case (state)
                IDLE: begin
                    if (pending) begin
                        active    <= shadow;
                        idx       <= '0;
                        pix_data  <= shadow[23:0];
                        pix_valid <= 1'b1;
                        pix_last  <= (NUM_LED == 1);
                        busy      <= 1'b1;
                        state     <= SEND;
                    end
                end
                SEND: begin
                    if (pix_ready) begin
                        if (idx == LAST) begin
                            pix_valid <= 1'b0;
                            pix_last  <= 1'b0;
                            state     <= WAIT_TX;
                        end else begin
                            idx      <= nxt;
                            pix_data <= active[32'(nxt)*24 +: 24];
                            pix_last <= (nxt == LAST);
                        end
                    end
                end
                WAIT_TX: begin
                    if (tx_idle) begin
                        if (LATCH_CYC <= 1) begin
                            frame_done <= 1'b1;
                            busy       <= 1'b0;
                            state      <= IDLE;
                        end else begin
                            state <= LATCH;
                        end
                    end
                end
                LATCH: begin
                    if (lat_done) begin
                        frame_done <= 1'b1;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ws2812_frame_scheduler.sv
// Scoreboard bench for ws2812_frame_scheduler with a short latch gap
// (1 MHz clock, 10 us gap -> 10 cycles).
module tb_ws2812_frame_scheduler;

    localparam int NL = 8;
    localparam int FW = NL * 24;
    localparam int CLK_HZ = 1_000_000;
    localparam int LUS = 10;
    localparam int L = CLK_HZ / 1_000_000 * LUS;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          frame_start = 1'b0;
    logic [FW-1:0] frame_data = '0;
    logic [23:0]   pix_data;
    logic          pix_valid;
    logic          pix_ready = 1'b0;
    logic          pix_last;
    logic          tx_idle = 1'b1;
    logic          busy;
    logic          frame_done;
    logic [7:0]    overrun_cnt;

    ws2812_frame_scheduler #(
        .NUM_LED (NL),
        .CLK_HZ  (CLK_HZ),
        .LATCH_US(LUS)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .frame_start(frame_start),
        .frame_data (frame_data),
        .pix_data   (pix_data),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .pix_last   (pix_last),
        .tx_idle    (tx_idle),
        .busy       (busy),
        .frame_done (frame_done),
        .overrun_cnt(overrun_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    logic [24:0] q[$];

    int rise_cnt = 0;
    int rise_cyc = -1;
    int done_cnt = 0;
    int done_cyc = -1;
    int last_acc_cyc = -1;

    logic        prev_v = 1'b0;
    logic        prev_r = 1'b0;
    logic [23:0] prev_d = '0;
    logic        prev_l = 1'b0;

    // Output monitor: scoreboard pops and hold-stability checks
    always @(negedge clk) begin
        logic [24:0] exp_w;
        if (reset) begin
            prev_v = 1'b0;
            prev_r = 1'b0;
        end else begin
            if (prev_v && !prev_r) begin
                n_cmp++;
                if (!pix_valid || pix_data !== prev_d || pix_last !== prev_l) begin
                    n_err++;
                    $display("FAIL hold: got v=%0b d=%h l=%0b, need v=1 d=%h l=%0b",
                             pix_valid, pix_data, pix_last, prev_d, prev_l);
                end
            end
            if (pix_valid && !prev_v) begin
                rise_cnt++;
                rise_cyc = cyc;
            end
            if (pix_valid && pix_ready) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_err++;
                    $display("FAIL word: got d=%h l=%0b, need no word", pix_data, pix_last);
                end else begin
                    exp_w = q.pop_front();
                    if ({pix_last, pix_data} !== exp_w) begin
                        n_err++;
                        $display("FAIL word: got d=%h l=%0b, need d=%h l=%0b",
                                 pix_data, pix_last, exp_w[23:0], exp_w[24]);
                    end
                end
                if (pix_last) last_acc_cyc = cyc;
            end
            if (frame_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            prev_v = pix_valid;
            prev_r = pix_ready;
            prev_d = pix_data;
            prev_l = pix_last;
        end
    end

    function automatic logic [FW-1:0] mk(input logic [7:0] seed, input bit basic);
        logic [FW-1:0] d;
        d = '0;
        for (int i = 0; i < NL; i++)
            d[i*24 +: 24] = basic ? 24'(i * 256) : {seed, 8'(i), seed ^ 8'(i)};
        return d;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input logic [FW-1:0] d);
        for (int i = 0; i < NL; i++)
            q.push_back({(i == NL - 1), d[i*24 +: 24]});
    endtask

    task automatic start_frame(input logic [FW-1:0] d, output int c);
        frame_data  = d;
        frame_start = 1'b1;
        c = cyc;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        frame_start = 1'b0;
        pix_ready = 1'b0;
        tx_idle = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        q.delete();
        tick();
    endtask

    task automatic wait_done(input int target, input int bound, output bit ok);
        for (int k = 0; k < bound && done_cnt < target; k++) tick();
        ok = (done_cnt >= target);
    endtask

    task automatic wait_rise(input int target, input int bound, output bit ok);
        for (int k = 0; k < bound && rise_cnt < target; k++) tick();
        ok = (rise_cnt >= target);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        n_cmp++;
        if ({pix_valid, pix_last, pix_data, busy, frame_done, overrun_cnt} !== '0) begin
            n_err++;
            $display("FAIL reset: got v=%0b l=%0b d=%h b=%0b fd=%0b o=%0d, need all 0",
                     pix_valid, pix_last, pix_data, busy, frame_done, overrun_cnt);
        end
    endtask

    task automatic test_basic();
        logic [FW-1:0] d;
        int c, r0, d0;
        bit ok;
        do_reset();
        pix_ready = 1'b1;
        d = mk(8'h00, 1'b1);
        push_frame(d);
        r0 = rise_cnt;
        d0 = done_cnt;
        start_frame(d, c);
        wait_rise(r0 + 1, 20, ok);
        n_cmp++;
        if (!ok || rise_cyc != c + 2) begin
            n_err++;
            $display("FAIL basic_latency: got cycle %0d, need %0d", rise_cyc, c + 2);
        end
        wait_done(d0 + 1, 100, ok);
        n_cmp++;
        if (!ok || done_cyc != last_acc_cyc + 1 + L) begin
            n_err++;
            $display("FAIL basic_done: got cycle %0d, need %0d", done_cyc, last_acc_cyc + 1 + L);
        end
        n_cmp++;
        if (q.size() != 0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL basic_end: got left=%0d busy=%0b, need 0 0", q.size(), busy);
        end
    endtask

    task automatic test_backpressure();
        logic [FW-1:0] d;
        int c, t, d0;
        bit ok;
        do_reset();
        tx_idle = 1'b0;
        d = mk(8'h00, 1'b1);
        push_frame(d);
        d0 = done_cnt;
        start_frame(d, c);
        for (int k = 0; k < 200 && q.size() != 0; k++) begin
            if (k % 3 == 2) pix_ready = ~pix_ready;
            tick();
        end
        n_cmp++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL bp_words: got %0d left, need 0", q.size());
        end
        pix_ready = 1'b1;
        repeat (4) tick();
        n_cmp++;
        if (pix_valid !== 1'b0 || busy !== 1'b1 || done_cnt != d0) begin
            n_err++;
            $display("FAIL bp_wait_tx: got v=%0b busy=%0b dones=%0d, need 0 1 %0d",
                     pix_valid, busy, done_cnt, d0);
        end
        tx_idle = 1'b1;
        t = cyc;
        wait_done(d0 + 1, 50, ok);
        n_cmp++;
        if (!ok || done_cyc != t + L) begin
            n_err++;
            $display("FAIL bp_done: got cycle %0d, need %0d", done_cyc, t + L);
        end
    endtask

    task automatic test_overrun();
        logic [FW-1:0] x, a, b, cc;
        int c, d0;
        bit ok;
        do_reset();
        x  = mk(8'h11, 1'b0);
        a  = mk(8'h22, 1'b0);
        b  = mk(8'h33, 1'b0);
        cc = mk(8'h44, 1'b0);
        push_frame(x);
        push_frame(cc);
        d0 = done_cnt;
        start_frame(x, c);
        repeat (3) tick();
        start_frame(a, c);
        n_cmp++;
        if (overrun_cnt !== 8'd0) begin
            n_err++;
            $display("FAIL ovr_a: got %0d, need 0", overrun_cnt);
        end
        start_frame(b, c);
        n_cmp++;
        if (overrun_cnt !== 8'd1) begin
            n_err++;
            $display("FAIL ovr_b: got %0d, need 1", overrun_cnt);
        end
        start_frame(cc, c);
        pix_ready = 1'b1;
        wait_done(d0 + 2, 200, ok);
        n_cmp++;
        if (!ok || q.size() != 0 || overrun_cnt !== 8'd2) begin
            n_err++;
            $display("FAIL ovr_end: got ok=%0b left=%0d ovr=%0d, need 1 0 2",
                     ok, q.size(), overrun_cnt);
        end
    endtask

    task automatic test_latch_gap();
        logic [FW-1:0] x, y;
        int c, r0, d0, xd;
        bit ok;
        do_reset();
        pix_ready = 1'b1;
        x = mk(8'h55, 1'b0);
        y = mk(8'h66, 1'b0);
        push_frame(x);
        d0 = done_cnt;
        start_frame(x, c);
        for (int k = 0; k < 50 && q.size() != 0; k++) tick();
        repeat (3) tick();
        push_frame(y);
        r0 = rise_cnt;
        start_frame(y, c);
        n_cmp++;
        if (busy !== 1'b1 || done_cnt != d0) begin
            n_err++;
            $display("FAIL gap_mid: got busy=%0b dones=%0d, need 1 %0d", busy, done_cnt, d0);
        end
        wait_done(d0 + 1, 50, ok);
        xd = done_cyc;
        wait_rise(r0 + 1, 20, ok);
        n_cmp++;
        if (!ok || rise_cyc != xd + 1) begin
            n_err++;
            $display("FAIL gap_next: got cycle %0d, need %0d", rise_cyc, xd + 1);
        end
        wait_done(d0 + 2, 100, ok);
        n_cmp++;
        if (!ok || q.size() != 0) begin
            n_err++;
            $display("FAIL gap_end: got ok=%0b left=%0d, need 1 0", ok, q.size());
        end
    endtask

    task automatic test_simultaneous();
        logic [FW-1:0] x, y;
        int c, r1, d0, xd;
        bit ok;
        do_reset();
        pix_ready = 1'b1;
        x = mk(8'h77, 1'b0);
        y = mk(8'h88, 1'b0);
        push_frame(x);
        push_frame(y);
        d0 = done_cnt;
        start_frame(x, c);
        start_frame(y, c);
        wait_done(d0 + 1, 100, ok);
        xd = done_cyc;
        r1 = rise_cnt;
        wait_rise(r1 + 1, 20, ok);
        n_cmp++;
        if (!ok || rise_cyc != xd + 1) begin
            n_err++;
            $display("FAIL simul_next: got cycle %0d, need %0d", rise_cyc, xd + 1);
        end
        wait_done(d0 + 2, 100, ok);
        n_cmp++;
        if (!ok || q.size() != 0 || overrun_cnt !== 8'd0) begin
            n_err++;
            $display("FAIL simul_end: got ok=%0b left=%0d ovr=%0d, need 1 0 0",
                     ok, q.size(), overrun_cnt);
        end
    endtask

    task automatic test_reset_mid();
        logic [FW-1:0] x, z;
        int c, r0, d0;
        bit ok;
        do_reset();
        x = mk(8'h99, 1'b0);
        z = mk(8'hAA, 1'b0);
        push_frame(x);
        r0 = rise_cnt;
        start_frame(x, c);
        wait_rise(r0 + 1, 20, ok);
        pix_ready = 1'b1;
        repeat (4) tick();
        pix_ready = 1'b0;
        start_frame(z, c);
        start_frame(z, c);
        n_cmp++;
        if (pix_data !== x[4*24 +: 24] || q.size() != 4 || overrun_cnt !== 8'd1) begin
            n_err++;
            $display("FAIL mid_idx4: got d=%h left=%0d ovr=%0d, need d=%h 4 1",
                     pix_data, q.size(), overrun_cnt, x[4*24 +: 24]);
        end
        reset = 1'b1;
        #1;
        n_cmp++;
        if (pix_valid !== 1'b0 || busy !== 1'b0 || overrun_cnt !== 8'd0) begin
            n_err++;
            $display("FAIL mid_reset: got v=%0b busy=%0b ovr=%0d, need 0 0 0",
                     pix_valid, busy, overrun_cnt);
        end
        q.delete();
        tick();
        reset = 1'b0;
        tick();
        pix_ready = 1'b1;
        push_frame(z);
        d0 = done_cnt;
        start_frame(z, c);
        wait_done(d0 + 1, 100, ok);
        n_cmp++;
        if (!ok || q.size() != 0) begin
            n_err++;
            $display("FAIL mid_restart: got ok=%0b left=%0d, need 1 0", ok, q.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_overrun();
        test_latch_gap();
        test_simultaneous();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ws2812_frame_scheduler.md
# ws2812_frame_scheduler

Sits between `pattern_controller` and the WS2812 bit serializer. It captures each `NUM_LED*24`-bit frame on the controller's `start` pulse into a shadow buffer. It streams the frame one 24-bit GRB word per LED over a valid/ready handshake, waits for the serializer to drain, then enforces the WS2812 latch/reset gap before the next frame. Frames that arrive while a transfer is in progress are buffered (single-deep, newest wins) and counted as overruns when they replace an unsent frame.

## Interface
- `NUM_LED`, 8, number of LEDs per frame (≥1).
- `CLK_HZ`, 100_000_000, clock frequency in Hz.
- `LATCH_US`, 60, minimum line-low gap after a frame, in µs; `LATCH_CYC = CLK_HZ/1_000_000*LATCH_US`.

Ports:
- `clk` in 1: clock.
- `reset` in 1: reset, asynchronous, active-high.
- `frame_start` in 1: one-cycle pulse; `frame_data` is valid this cycle.
- `frame_data` in NUM_LED*24: LED i occupies bits [i*24 +: 24], GRB order.
- `pix_data` out 24: current LED word.
- `pix_valid` out 1: `pix_data` is valid.
- `pix_ready` in 1: serializer accepts the word when `pix_valid && pix_ready`.
- `pix_last` out 1: high with `pix_valid` for LED NUM_LED-1.
- `tx_idle` in 1: serializer has shifted out all accepted bits.
- `busy` out 1: state ≠ IDLE.
- `frame_done` out 1: one-cycle pulse at the end of the latch gap.
- `overrun_cnt` out 8: saturating count of overwritten pending frames.

## Operation
- Buffers:
  - `shadow` (NUM_LED*24) plus a `pending` flag.
  - `active` (NUM_LED*24) plus an LED index `idx` of width clog2(NUM_LED), minimum 1.
- Capture: `frame_start` in any state writes `shadow` and sets `pending`. If `pending` is already set and not consumed that cycle, also increment `overrun_cnt`; it saturates at 255.
- States:
  - IDLE: if `pending`, copy `shadow` to `active`, clear `pending`, set `idx`=0, go to SEND.
  - SEND: `pix_valid`=1 and `pix_data`=`active[idx*24 +: 24]`. On accept, `idx`++. An accept at `idx`=NUM_LED-1 goes to WAIT_TX.
  - WAIT_TX: `pix_valid`=0. Once `tx_idle`=1, load `lat_cnt`=LATCH_CYC-1 and go to LATCH.
  - LATCH: decrement `lat_cnt`. At 0, pulse `frame_done` and go to IDLE.
- Simultaneous consume and capture: IDLE consumes `pending` in the same cycle as a new `frame_start`.
  - `active` gets the old `shadow`.
  - `shadow` gets the new data, and `pending` stays set.
  - No overrun is counted.
- A `frame_start` during SEND, WAIT_TX or LATCH never disturbs `active` or `idx`.
- NUM_LED=1: the first accepted word asserts `pix_last` and goes directly to WAIT_TX.
- Mid-operation `reset` clears all state immediately. The frame is abandoned, and the serializer must also be reset.

## Timing
- Reset values: `pix_valid`=0, `pix_last`=0, `pix_data`=0, `busy`=0, `frame_done`=0, `overrun_cnt`=0, `pending`=0, state IDLE.
- `frame_start` at cycle N in IDLE:
  - `pending`=1 at N+1.
  - SEND is entered and `pix_valid`=1 at N+2.
- Handshake rules:
  - `pix_data` and `pix_last` hold stable while `pix_valid && !pix_ready`.
  - `pix_valid` never drops without an accept.
  - With `pix_ready` tied high, one word is accepted per cycle.
- Accept of the last word at cycle M: `pix_valid`=0 at M+1.
- `tx_idle` first seen high at cycle T in WAIT_TX: `frame_done` at T+LATCH_CYC.
- IDLE with `pending` at cycle D: next `pix_valid` at D+1. The minimum gap from `frame_done` to the next `pix_valid` is 1 cycle.
- All outputs are registered.

## Structure
- Package `ws2812_pkg`:
  - State enum (IDLE, SEND, WAIT_TX, LATCH).
  - GRB color constants shared with `pattern_controller`.
  - Default `LATCH_US`, plus the `LATCH_CYC` derivation function.
- One sub-module, `ws2812_latch_timer`: load/decrement counter with a `done` pulse, width clog2(LATCH_CYC).

## Test plan
- Basic frame: NUM_LED=8, `frame_data` LED i = 24'h000100*i, `pix_ready`=1, `tx_idle`=1. Expect:
  - `pix_valid` 2 cycles after `frame_start`.
  - Words 0x000000..0x000700 in order, `pix_last` on the 8th.
  - `frame_done` LATCH_CYC cycles after WAIT_TX.
- Backpressure: `pix_ready` toggles every 3 cycles → same 8 words, each held stable until accepted, no duplicates or drops.
- Overrun: three `frame_start` pulses (A, B, C) during SEND of frame X → X completes, then only C is sent, and `overrun_cnt`=2.
- Latch gap: `frame_start` mid-LATCH → next `pix_valid` exactly 1 cycle after `frame_done`, never earlier.
- Simultaneous event: `frame_start` in the cycle IDLE consumes `pending` → old frame sent first, new frame sent after the next latch, `overrun_cnt` unchanged.
- Reset mid-SEND at `idx`=4 → `pix_valid`=0 and `busy`=0 immediately, with `overrun_cnt`=0. The next `frame_start` restarts from LED 0.
